branch_resolve_unit: RTL and testbench



---
 rtl/branch_resolve_unit_pkg.sv | 26 ++
 rtl/brq_fifo.sv | 70 +++++++
 rtl/branch_resolve_unit.sv | 129 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: fall-through PC increment
// and the layout of a queued branch entry {pred, pc, target}.
package branch_resolve_unit_pkg;

   // Sequential fetch advances by one 32-bit instruction.
   localparam int unsigned PC_INC = 4;

   // Entry is {pred, pc, target}: target in the low PC_W bits, pc above it,
   // pred in the single top bit.
   function automatic int unsigned entry_w(input int unsigned pc_w);
      return 1 + 2 * pc_w;
   endfunction

   function automatic int unsigned tgt_ofs(input int unsigned pc_w);
      return 0 * pc_w;
   endfunction

   function automatic int unsigned pc_ofs(input int unsigned pc_w);
      return pc_w;
   endfunction

   function automatic int unsigned pred_ofs(input int unsigned pc_w);
      return 2 * pc_w;
   endfunction

endpackage

// File: rtl/brq_fifo.sv
// In-order circular queue of in-flight branches.
// Ports: push_i/data_i enqueue, pop_i dequeues the head, clear_i empties the
// queue (wins over push and pop), full_o/empty_o status, head_o oldest entry.
module brq_fifo
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 65
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] count;
   logic [W-1:0]  mem_q [DEPTH];

   logic do_push;
   logic do_pop;

   assign count   = wr_q - rd_q;
   assign full_o  = (count == PW'(DEPTH));
   assign empty_o = (count == '0);
   assign head_o  = mem_q[rd_q[AW-1:0]];

   assign do_push = push_i && !full_o && !clear_i;
   assign do_pop  = pop_i && !empty_o && !clear_i;

   // Next pointer values; clear resets both pointers.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (clear_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PW'(1);
         if (do_pop)  rd_d = rd_q + PW'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Entry storage; contents are only meaningful between rd and wr.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues predicted branches from IF, compares each with
// its EX outcome, and drives predictor update, flush and redirect PC.
// Ports: issue_* from IF (stall_o back-pressure), resolve_* from EX,
// update_o/result_o to the predictor, flush_o/redirect_pc_o to fetch,
// err_o sticky resolve-without-branch error, branch/mispredict counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_valid_i,
   input  logic             issue_pred_i,
   input  logic [PC_W-1:0]  issue_pc_i,
   input  logic [PC_W-1:0]  issue_target_i,
   output logic             stall_o,
   input  logic             resolve_valid_i,
   input  logic             resolve_taken_i,
   output logic             update_o,
   output logic             result_o,
   output logic             flush_o,
   output logic [PC_W-1:0]  redirect_pc_o,
   output logic             err_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam int unsigned EW    = entry_w(PC_W);
   localparam int unsigned T_OFS = tgt_ofs(PC_W);
   localparam int unsigned P_OFS = pc_ofs(PC_W);
   localparam int unsigned D_OFS = pred_ofs(PC_W);

   logic            full;
   logic            empty;
   logic [EW-1:0]   head;
   logic            head_pred;
   logic [PC_W-1:0] head_pc;
   logic [PC_W-1:0] head_tgt;
   logic            pop;
   logic            mis;
   logic            push;

   logic             update_q,   update_d;
   logic             result_q,   result_d;
   logic             flush_q,    flush_d;
   logic [PC_W-1:0]  redirect_q, redirect_d;
   logic             err_q,      err_d;
   logic [CNT_W-1:0] bcnt_q,     bcnt_d;
   logic [CNT_W-1:0] mcnt_q,     mcnt_d;

   assign head_pred = head[D_OFS];
   assign head_pc   = head[P_OFS +: PC_W];
   assign head_tgt  = head[T_OFS +: PC_W];

   // A mispredict flushes everything younger, including a same-cycle issue.
   assign pop  = resolve_valid_i && !empty;
   assign mis  = pop && (head_pred != resolve_taken_i);
   assign push = issue_valid_i && !full && !mis;

   assign stall_o = full;

   brq_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (mis),
      .data_i  ({issue_pred_i, issue_pc_i, issue_target_i}),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );

   // Resolve outcome, redirect and counter updates.
   always_comb begin
      update_d   = pop;
      result_d   = result_q;
      flush_d    = mis;
      redirect_d = redirect_q;
      err_d      = err_q;
      bcnt_d     = bcnt_q;
      mcnt_d     = mcnt_q;
      if (pop) begin
         result_d = resolve_taken_i;
         bcnt_d   = bcnt_q + CNT_W'(1);
      end
      if (mis) begin
         redirect_d = resolve_taken_i ? head_tgt : head_pc + PC_W'(PC_INC);
         mcnt_d     = mcnt_q + CNT_W'(1);
      end
      if (resolve_valid_i && empty) err_d = 1'b1;
   end

   // Output and counter registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         update_q   <= 1'b0;
         result_q   <= 1'b0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
         err_q      <= 1'b0;
         bcnt_q     <= '0;
         mcnt_q     <= '0;
      end else begin
         update_q   <= update_d;
         result_q   <= result_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         err_q      <= err_d;
         bcnt_q     <= bcnt_d;
         mcnt_q     <= mcnt_d;
      end
   end

   assign update_o      = update_q;
   assign result_o      = result_q;
   assign flush_o       = flush_q;
   assign redirect_pc_o = redirect_q;
   assign err_o         = err_q;
   assign branch_cnt_o  = bcnt_q;
   assign mispred_cnt_o = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed issue/resolve vectors push the
// expected predictor-update response into a queue; a negedge monitor pops
// and compares on every update pulse.
module tb_branch_resolve_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        issue_valid_i = 1'b0;
   logic        issue_pred_i = 1'b0;
   logic [31:0] issue_pc_i = '0;
   logic [31:0] issue_target_i = '0;
   logic        stall_o;
   logic        resolve_valid_i = 1'b0;
   logic        resolve_taken_i = 1'b0;
   logic        update_o;
   logic        result_o;
   logic        flush_o;
   logic [31:0] redirect_pc_o;
   logic        err_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispred_cnt_o;

   typedef struct packed {
      logic        result;
      logic        flush;
      logic [31:0] redir;
      logic [31:0] bcnt;
      logic [31:0] mcnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   branch_resolve_unit #(
      .DEPTH (4),
      .PC_W  (32),
      .CNT_W (32)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .issue_valid_i   (issue_valid_i),
      .issue_pred_i    (issue_pred_i),
      .issue_pc_i      (issue_pc_i),
      .issue_target_i  (issue_target_i),
      .stall_o         (stall_o),
      .resolve_valid_i (resolve_valid_i),
      .resolve_taken_i (resolve_taken_i),
      .update_o        (update_o),
      .result_o        (result_o),
      .flush_o         (flush_o),
      .redirect_pc_o   (redirect_pc_o),
      .err_o           (err_o),
      .branch_cnt_o    (branch_cnt_o),
      .mispred_cnt_o   (mispred_cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one cycle of inputs; returns 1 time unit after the capturing edge.
   task automatic step(input bit iv, input bit pred, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit rv, input bit taken);
      issue_valid_i   = iv;
      issue_pred_i    = pred;
      issue_pc_i      = pc;
      issue_target_i  = tgt;
      resolve_valid_i = rv;
      resolve_taken_i = taken;
      @(posedge clk_i);
      #1;
      issue_valid_i   = 1'b0;
      resolve_valid_i = 1'b0;
   endtask

   task automatic expect_upd(input bit result, input bit flush, input logic [31:0] redir,
                             input logic [31:0] bcnt, input logic [31:0] mcnt);
      exp_t e;
      e.result = result;
      e.flush  = flush;
      e.redir  = redir;
      e.bcnt   = bcnt;
      e.mcnt   = mcnt;
      exp_q.push_back(e);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_update"},   32'(update_o), 32'd0);
      chk({tag, "_result"},   32'(result_o), 32'd0);
      chk({tag, "_flush"},    32'(flush_o), 32'd0);
      chk({tag, "_err"},      32'(err_o), 32'd0);
      chk({tag, "_redirect"}, redirect_pc_o, 32'd0);
      chk({tag, "_bcnt"},     branch_cnt_o, 32'd0);
      chk({tag, "_mcnt"},     mispred_cnt_o, 32'd0);
      chk({tag, "_stall"},    32'(stall_o), 32'd0);
   endtask

   // Monitor: every update pulse must match the oldest expected response.
   always @(negedge clk_i) begin
      if (rst_i && update_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_update actual=1 required=0 at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_result",   32'(result_o), 32'(e.result));
            chk("mon_flush",    32'(flush_o), 32'(e.flush));
            chk("mon_redirect", redirect_pc_o, e.redir);
            chk("mon_bcnt",     branch_cnt_o, e.bcnt);
            chk("mon_mcnt",     mispred_cnt_o, e.mcnt);
         end
      end
   end

   initial begin
      // Reset state.
      repeat (2) @(posedge clk_i);
      #1;
      chk_reset_state("rst0");
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Correct taken prediction.
      step(1, 1, 32'h100, 32'h140, 0, 0);
      expect_upd(1, 0, 32'h0, 32'd1, 32'd0);
      step(0, 0, 0, 0, 1, 1);

      // Predicted taken, actually not taken: fall-through redirect.
      step(1, 1, 32'h200, 32'h280, 0, 0);
      expect_upd(0, 1, 32'h204, 32'd2, 32'd1);
      step(0, 0, 0, 0, 1, 0);
      chk("t2_stall", 32'(stall_o), 32'd0);

      // Predicted not taken, actually taken: target redirect.
      step(1, 0, 32'h300, 32'h3C0, 0, 0);
      expect_upd(1, 1, 32'h3C0, 32'd3, 32'd2);
      step(0, 0, 0, 0, 1, 1);

      // Fill queue, held 5th issue, resolve while full.
      step(1, 1, 32'h400, 32'h480, 0, 0);
      step(1, 1, 32'h410, 32'h490, 0, 0);
      step(1, 1, 32'h420, 32'h4A0, 0, 0);
      chk("t4_stall_3", 32'(stall_o), 32'd0);
      step(1, 1, 32'h430, 32'h4B0, 0, 0);
      chk("t4_stall_4", 32'(stall_o), 32'd1);
      step(1, 1, 32'h440, 32'h4C0, 0, 0);
      chk("t4_stall_held", 32'(stall_o), 32'd1);
      expect_upd(1, 0, 32'h3C0, 32'd4, 32'd2);
      step(1, 1, 32'h440, 32'h4C0, 1, 1);
      chk("t4_stall_drop", 32'(stall_o), 32'd0);
      step(1, 1, 32'h440, 32'h4C0, 0, 0);
      chk("t4_stall_refill", 32'(stall_o), 32'd1);
      // Back-to-back resolves, last one mispredicts.
      expect_upd(1, 0, 32'h3C0, 32'd5, 32'd2);
      step(0, 0, 0, 0, 1, 1);
      expect_upd(1, 0, 32'h3C0, 32'd6, 32'd2);
      step(0, 0, 0, 0, 1, 1);
      expect_upd(1, 0, 32'h3C0, 32'd7, 32'd2);
      step(0, 0, 0, 0, 1, 1);
      expect_upd(0, 1, 32'h444, 32'd8, 32'd3);
      step(0, 0, 0, 0, 1, 0);
      chk("t4_err_clear", 32'(err_o), 32'd0);

      // Mispredict with younger entries and a same-cycle issue.
      step(1, 0, 32'h500, 32'h5A0, 0, 0);
      step(1, 1, 32'h510, 32'h590, 0, 0);
      step(1, 1, 32'h520, 32'h5B0, 0, 0);
      expect_upd(1, 1, 32'h5A0, 32'd9, 32'd4);
      step(1, 1, 32'h530, 32'h5C0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      chk("t5_err", 32'(err_o), 32'd1);
      chk("t5_bcnt_hold", branch_cnt_o, 32'd9);
      chk("t5_mcnt_hold", mispred_cnt_o, 32'd4);
      step(0, 0, 0, 0, 0, 0);
      chk("t5_err_sticky", 32'(err_o), 32'd1);

      // Asynchronous reset while a flush pulse is on the outputs.
      step(1, 0, 32'h600, 32'h6A0, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      chk("t6_flush_pre", 32'(flush_o), 32'd1);
      chk("t6_redirect_pre", redirect_pc_o, 32'h6A0);
      issue_valid_i  = 1'b1;
      issue_pred_i   = 1'b1;
      issue_pc_i     = 32'h700;
      issue_target_i = 32'h780;
      #1;
      rst_i = 1'b0;
      #1;
      chk_reset_state("t6_async");
      @(posedge clk_i);
      #1;
      issue_valid_i = 1'b0;
      rst_i = 1'b1;
      chk("t6_stall_post", 32'(stall_o), 32'd0);

      // Queue must be empty after reset: new branch resolves as the head.
      step(1, 1, 32'h800, 32'h880, 0, 0);
      expect_upd(1, 0, 32'h0, 32'd1, 32'd0);
      step(0, 0, 0, 0, 1, 1);

      repeat (3) @(posedge clk_i);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
